// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and constants for the TX FIFO arbiter
package tx_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef logic [0:0] req_id_t;

endpackage

// File: rtl/arb_idle_timer.sv
// arb_idle_timer: saturating owner-stall counter with expiry flag; TIMEOUT_CYCLES=0 disables expiry
module arb_idle_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic CLR_I,
    input  logic INC_I,
    output logic EXPIRE_O
);

    localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [W-1:0] cnt;

    // count stall cycles, holding at all-ones instead of wrapping
    always_ff @(posedge CLK_I) begin
        if (RST_I || CLR_I)
            cnt <= '0;
        else if (INC_I && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign EXPIRE_O = (TIMEOUT_CYCLES > 0) && (cnt == LIM);

endmodule

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: packet-atomic round-robin sharing of the TX FIFO write port between two requesters
module tx_fifo_arbiter
    import tx_arb_pkg::*;
#(
    parameter int DBITS          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [NUM_REQ-1:0]       REQ_VALID_I,
    input  logic [NUM_REQ*DBITS-1:0] REQ_DATA_I,
    input  logic [NUM_REQ-1:0]       REQ_LAST_I,
    output logic [NUM_REQ-1:0]       REQ_READY_O,
    output logic                     FIFO_WE_O,
    output logic [DBITS-1:0]         FIFO_W_DATA_O,
    input  logic                     FIFO_FULL_I,
    input  logic                     FIFO_HALF_FULL_I,
    output logic [NUM_REQ-1:0]       GRANT_O,
    output logic                     TIMEOUT_O,
    output logic                     TIMEOUT_ID_O
);

    state_t             state, state_nxt;
    req_id_t            owner, owner_nxt, rr_last, rr_last_nxt;
    logic [NUM_REQ-1:0] eligible;
    logic               busy, own_valid, expire;

    assign busy      = state == BUSY;
    assign own_valid = REQ_VALID_I[owner];

    // bulk traffic backs off at half-full so debug responses keep headroom
    assign eligible = {REQ_VALID_I[1] & ~FIFO_FULL_I & ~FIFO_HALF_FULL_I,
                       REQ_VALID_I[0] & ~FIFO_FULL_I};

    assign GRANT_O       = {busy & owner, busy & ~owner};
    assign REQ_READY_O   = GRANT_O & {NUM_REQ{~FIFO_FULL_I}};
    assign FIFO_WE_O     = busy & own_valid & ~FIFO_FULL_I;
    assign FIFO_W_DATA_O = !FIFO_WE_O ? '0 : owner ? REQ_DATA_I[DBITS +: DBITS] : REQ_DATA_I[0 +: DBITS];
    assign TIMEOUT_O     = busy & ~own_valid & expire;
    assign TIMEOUT_ID_O  = TIMEOUT_O & owner;

    // a full FIFO with valid high is back-pressure, not a stall, so valid alone clears the count
    arb_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .CLR_I   (~busy | own_valid),
        .INC_I   (busy & ~own_valid),
        .EXPIRE_O(expire)
    );

    // register FSM state, current owner and round-robin history
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= IDLE;
            owner   <= '0;
            rr_last <= 1'b1;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_last <= rr_last_nxt;
        end
    end

    // grant in IDLE; release on accepted LAST or watchdog expiry in BUSY
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_last_nxt = rr_last;
        if (!busy && |eligible) begin
            state_nxt = BUSY;
            owner_nxt = &eligible ? ~rr_last : req_id_t'(eligible[1]);
        end
        if (busy && ((FIFO_WE_O && REQ_LAST_I[owner]) || TIMEOUT_O)) begin
            state_nxt   = IDLE;
            rr_last_nxt = owner;
        end
    end

endmodule
